// File: rtl/encoder.sv
// Registered 4-to-2 priority encoder with valid and multi-hot flags.
// MSB_PRIORITY picks whether the highest (1) or lowest (0) set bit wins.
module encoder #(
  parameter int MSB_PRIORITY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] encoder_in,
  output logic [1:0] encoder_out,
  output logic       valid,
  output logic       multi_hot
);

  logic [1:0] encIdx_d;
  logic [1:0] encIdx_q;
  logic       valid_d;
  logic       valid_q;
  logic       multiHot_d;
  logic       multiHot_q;

  // Later loop iterations overwrite earlier ones, so the scan order sets priority.
  always_comb begin
    encIdx_d = 2'b00;
    if (MSB_PRIORITY != 0) begin
      for (int i = 0; i < 4; i++) begin
        if (encoder_in[i]) begin
          encIdx_d = 2'(i);
        end
      end
    end else begin
      for (int i = 3; i >= 0; i--) begin
        if (encoder_in[i]) begin
          encIdx_d = 2'(i);
        end
      end
    end
    valid_d    = |encoder_in;
    // Clearing the lowest set bit leaves something only if two or more were set.
    multiHot_d = (encoder_in & (encoder_in - 4'd1)) != 4'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      encIdx_q   <= 2'b00;
      valid_q    <= 1'b0;
      multiHot_q <= 1'b0;
    end else if (en) begin
      encIdx_q   <= encIdx_d;
      valid_q    <= valid_d;
      multiHot_q <= multiHot_d;
    end
  end

  assign encoder_out = encIdx_q;
  assign valid       = valid_q;
  assign multi_hot   = multiHot_q;

endmodule

// File: tb/tb_encoder.sv
// Scoreboard bench for encoder: both priority settings run side by side on
// the same stimulus, each checked against hand-computed expectations.
module tb_encoder;

  typedef struct packed {
    logic [1:0] outMsb;
    logic [1:0] outLsb;
    logic       valid;
    logic       multi;
  } expect_t;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] encIn;
  logic [1:0] outMsb;
  logic       validMsb;
  logic       multiMsb;
  logic [1:0] outLsb;
  logic       validLsb;
  logic       multiLsb;

  expect_t expQ[$];
  int      nVectors;
  int      nMiscompares;
  bit      driverDone;

  encoder #(.MSB_PRIORITY(1)) dutMsb (
    .clk(clk), .rst_n(rst_n), .en(en), .encoder_in(encIn),
    .encoder_out(outMsb), .valid(validMsb), .multi_hot(multiMsb)
  );

  encoder #(.MSB_PRIORITY(0)) dutLsb (
    .clk(clk), .rst_n(rst_n), .en(en), .encoder_in(encIn),
    .encoder_out(outLsb), .valid(validLsb), .multi_hot(multiLsb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got out/valid/multi=%b/%b/%b, expected %b/%b/%b",
               name, actual[3:2], actual[1], actual[0], expected[3:2], expected[1], expected[0]);
    end
  endtask

  // Drive one cycle of stimulus and queue what both DUTs should show after the edge.
  task automatic applyStimulus(input logic enVal, input logic [3:0] inVal,
                               input logic [1:0] eMsb, input logic [1:0] eLsb,
                               input logic eValid, input logic eMulti);
    expect_t e;
    @(negedge clk);
    en    = enVal;
    encIn = inVal;
    e.outMsb = eMsb;
    e.outLsb = eLsb;
    e.valid  = eValid;
    e.multi  = eMulti;
    expQ.push_back(e);
    @(posedge clk);
  endtask

  // Monitor: after every edge out of reset, pop one expectation and compare both DUTs.
  initial begin
    expect_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("msbDut", {outMsb, validMsb, multiMsb}, {e.outMsb, e.valid, e.multi});
        checkOutput("lsbDut", {outLsb, validLsb, multiLsb}, {e.outLsb, e.valid, e.multi});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    nVectors     = 0;
    nMiscompares = 0;
    driverDone   = 1'b0;
    rst_n = 1'b0;
    en    = 1'b1;
    encIn = 4'b1111;

    // Reset state, before and across a clock edge with a live sample on the inputs.
    #3;
    checkOutput("resetMsb", {outMsb, validMsb, multiMsb}, 4'b0000);
    checkOutput("resetLsb", {outLsb, validLsb, multiLsb}, 4'b0000);
    @(posedge clk);
    #1;
    checkOutput("resetEdgeMsb", {outMsb, validMsb, multiMsb}, 4'b0000);
    checkOutput("resetEdgeLsb", {outLsb, validLsb, multiLsb}, 4'b0000);
    @(negedge clk);
    en    = 1'b0;
    rst_n = 1'b1;

    // One-hot sweep.
    applyStimulus(1'b1, 4'b0001, 2'b00, 2'b00, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'b0010, 2'b01, 2'b01, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'b0100, 2'b10, 2'b10, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'b1000, 2'b11, 2'b11, 1'b1, 1'b0);
    // Zero input after 1000.
    applyStimulus(1'b1, 4'b0000, 2'b00, 2'b00, 1'b0, 1'b0);
    // Multi-hot sweep.
    applyStimulus(1'b1, 4'b0011, 2'b01, 2'b00, 1'b1, 1'b1);
    applyStimulus(1'b1, 4'b0101, 2'b10, 2'b00, 1'b1, 1'b1);
    applyStimulus(1'b1, 4'b1001, 2'b11, 2'b00, 1'b1, 1'b1);
    applyStimulus(1'b1, 4'b0110, 2'b10, 2'b01, 1'b1, 1'b1);
    applyStimulus(1'b1, 4'b1010, 2'b11, 2'b01, 1'b1, 1'b1);
    applyStimulus(1'b1, 4'b1100, 2'b11, 2'b10, 1'b1, 1'b1);
    applyStimulus(1'b1, 4'b0111, 2'b10, 2'b00, 1'b1, 1'b1);
    // Enable hold.
    applyStimulus(1'b1, 4'b0100, 2'b10, 2'b10, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 4'b0001, 2'b10, 2'b10, 1'b1, 1'b0);
    end
    applyStimulus(1'b1, 4'b0001, 2'b00, 2'b00, 1'b1, 1'b0);
    // All ones, then asynchronous reset mid-cycle with a pending sample.
    applyStimulus(1'b1, 4'b1111, 2'b11, 2'b00, 1'b1, 1'b1);
    #3;
    en    = 1'b1;
    encIn = 4'b1010;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncRstMsb", {outMsb, validMsb, multiMsb}, 4'b0000);
    checkOutput("asyncRstLsb", {outLsb, validLsb, multiLsb}, 4'b0000);
    @(posedge clk);
    #1;
    checkOutput("rstHoldMsb", {outMsb, validMsb, multiMsb}, 4'b0000);
    checkOutput("rstHoldLsb", {outLsb, validLsb, multiLsb}, 4'b0000);
    @(negedge clk);
    en    = 1'b0;
    rst_n = 1'b1;
    applyStimulus(1'b0, 4'b1010, 2'b00, 2'b00, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'b1000, 2'b11, 2'b11, 1'b1, 1'b0);
    driverDone = 1'b1;
  end

  // Drain the scoreboard with a bounded wait, then report.
  initial begin
    wait (driverDone);
    for (int i = 0; i < 10 && expQ.size() > 0; i++) begin
      @(posedge clk);
    end
    repeat (2) @(posedge clk);
    if (expQ.size() != 0) begin
      nVectors++;
      nMiscompares++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
